cpu_phase_ctrl: RTL and testbench

Multi-cycle sequencer for the 8-bit accumulator CPU. It steps an 8-phase instruction cycle and decodes the current 3-bit opcode into control strobes. It sits directly upstream of the program counter: `inc_pc` drives the PC's `en` and `ld_pc` drives its `load`. It also drives the instruction register, accumulator, memory and data-bus enables. Memory-wait stalling is optional.

---
 rtl/cpu_phase_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_phase_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_phase_ctrl.sv
// 8-phase instruction sequencer and control-strobe decoder for the 8-bit accumulator CPU.
// Optional memory-wait stalling in phases 1 and 5 is enabled with CTRL_MEM_WAIT_EN.
module cpu_phase_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       halt,
   output logic       inc_pc,
   output logic       ld_pc,
   output logic       ld_ac,
   output logic       wr,
   output logic       data_e,
   output logic [2:0] phase
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   phase_t state, state_nxt;
   logic   halted, halted_nxt;
   logic   aluop;

   assign aluop = (opcode == ADD) || (opcode == AND) || (opcode == XOR) || (opcode == LDA);
   assign phase = state;

`ifndef CTRL_MEM_WAIT_EN
   logic unused_mem_ready;
   assign unused_mem_ready = mem_ready;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INST_ADDR;
         halted <= 1'b0;
      end else begin
         state  <= state_nxt;
         halted <= halted_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      halted_nxt = halted;
      if (!halted) begin
         // HLT freezes the phase at OP_ADDR; only rst leaves this state
         if (state == OP_ADDR && opcode == HLT) begin
            halted_nxt = 1'b1;
         end else begin
            state_nxt = phase_t'(state + 3'd1);
`ifdef CTRL_MEM_WAIT_EN
            if (!mem_ready && ((state == INST_FETCH) || (state == OP_FETCH && aluop)))
               state_nxt = state;
`endif
         end
      end
   end

   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      halt   = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      if (halted) begin
         halt = 1'b1;
      end else begin
         case (state)
            INST_ADDR: begin
               sel = 1'b1;
            end
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (opcode == HLT);
            end
            OP_FETCH: begin
               rd = aluop;
            end
            ALU_OP: begin
               rd     = aluop;
               inc_pc = (opcode == SKZ) && zero;
               ld_pc  = (opcode == JMP);
               data_e = (opcode == STO);
            end
            STORE: begin
               rd     = aluop;
               ld_ac  = aluop;
               ld_pc  = (opcode == JMP);
               wr     = (opcode == STO);
               data_e = (opcode == STO);
            end
            default: begin
               sel = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Self-checking bench for cpu_phase_ctrl: directed scenarios plus randomized stimulus
// against a phase/halt reference model; honours CTRL_MEM_WAIT_EN when defined.
module tb_cpu_phase_ctrl;

   logic       clk;
   logic       rst;
   logic [2:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e;
   logic [2:0] phase;
   logic [11:0] obs;
   logic [11:0] ex;

   int vectors = 0;
   int miscompares = 0;
   int m_phase;
   bit m_halted;

   cpu_phase_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .sel(sel), .rd(rd), .ld_ir(ld_ir), .halt(halt), .inc_pc(inc_pc), .ld_pc(ld_pc),
      .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .phase(phase)
   );

   assign obs = {sel, rd, ld_ir, halt, inc_pc, ld_pc, ld_ac, wr, data_e, phase};

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected strobes {sel,rd,ld_ir,halt,inc_pc,ld_pc,ld_ac,wr,data_e,phase}
   function automatic logic [11:0] exp_out(int p, logic [2:0] op, logic z, bit h);
      bit alu;
      logic [2:0] pb;
      alu = (op >= 3'd2) && (op <= 3'd5);
      pb  = p[2:0];
      if (h) return {3'b000, 1'b1, 5'b00000, pb};
      return {p <= 3,
              (p >= 1 && p <= 3) || (p >= 5 && alu),
              p == 2 || p == 3,
              p == 4 && op == 3'd0,
              p == 4 || (p == 6 && op == 3'd1 && z),
              (p == 6 || p == 7) && op == 3'd7,
              p == 7 && alu,
              p == 7 && op == 3'd6,
              (p == 6 || p == 7) && op == 3'd6,
              pb};
   endfunction

   // One rising edge; the model follows using the inputs held across that edge.
   task automatic tick();
      bit stall;
      @(posedge clk);
`ifdef CTRL_MEM_WAIT_EN
      stall = !mem_ready && (m_phase == 1 || (m_phase == 5 && opcode >= 3'd2 && opcode <= 3'd5));
`else
      stall = 1'b0;
`endif
      if (rst) begin
         m_phase  = 0;
         m_halted = 1'b0;
      end else if (!m_halted) begin
         if (m_phase == 4 && opcode == 3'd0) m_halted = 1'b1;
         else if (!stall) m_phase = (m_phase + 1) % 8;
      end
   endtask

   // Called at a falling edge; returns at a falling edge with rst released.
   task automatic do_reset();
      rst = 1'b1;
      m_phase  = 0;
      m_halted = 1'b0;
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if (obs !== 12'b1000_0000_0000) begin
         miscompares++;
         $display("FAIL reset_state: got %b want %b", obs, 12'b1000_0000_0000);
      end
      @(negedge clk);
      rst = 1'b0; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         @(negedge clk);
      end
      rst = 1'b1;
      m_phase = 0; m_halted = 1'b0;
      #1;
      vectors++;
      if (obs !== 12'b1000_0000_0000) begin
         miscompares++;
         $display("FAIL async_reset_mid: got %b want %b", obs, 12'b1000_0000_0000);
      end
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_opcode_cycle(input logic [2:0] op, input logic z, input string name);
      do_reset();
      for (int i = 0; i < 17; i++) begin
         opcode = op; zero = z; mem_ready = 1'b1;
         #1;
         ex = exp_out(m_phase, opcode, zero, m_halted);
         vectors++;
         if (obs !== ex) begin
            miscompares++;
            $display("FAIL %s cyc%0d: got %b want %b", name, i, obs, ex);
         end
         tick();
         @(negedge clk);
      end
   endtask

   task automatic test_hlt();
      do_reset();
      for (int i = 0; i < 26; i++) begin
         opcode = 3'd0; zero = 1'($urandom_range(0, 1)); mem_ready = 1'b1;
         #1;
         ex = exp_out(m_phase, opcode, zero, m_halted);
         vectors++;
         if (obs !== ex) begin
            miscompares++;
            $display("FAIL hlt cyc%0d: got %b want %b", i, obs, ex);
         end
         tick();
         @(negedge clk);
      end
      vectors++;
      if (phase !== 3'd4 || halt !== 1'b1 || inc_pc !== 1'b0) begin
         miscompares++;
         $display("FAIL hlt_frozen: got phase=%0d halt=%b inc_pc=%b want 4/1/0", phase, halt, inc_pc);
      end
      rst = 1'b1;
      m_phase = 0; m_halted = 1'b0;
      #1;
      vectors++;
      if (obs !== 12'b1000_0000_0000) begin
         miscompares++;
         $display("FAIL hlt_reset: got %b want %b", obs, 12'b1000_0000_0000);
      end
      tick();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_mem_wait();
      logic mr_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         opcode = 3'd2; zero = 1'b0; mem_ready = mr_seq[i];
         #1;
         ex = exp_out(m_phase, opcode, zero, m_halted);
         vectors++;
         if (obs !== ex) begin
            miscompares++;
            $display("FAIL mem_wait cyc%0d: got %b want %b", i, obs, ex);
         end
         tick();
         @(negedge clk);
      end
      #1;
      vectors++;
`ifdef CTRL_MEM_WAIT_EN
      if (phase !== 3'd2) begin
         miscompares++;
         $display("FAIL mem_wait_resume: got phase %0d want 2", phase);
      end
`else
      if (phase !== 3'd5) begin
         miscompares++;
         $display("FAIL mem_wait_ignored: got phase %0d want 5", phase);
      end
`endif
      @(negedge clk);
      m_phase = (m_phase + 1) % 8;
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         opcode    = 3'($urandom_range(0, 7));
         zero      = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 49) == 0);
         if (rst) begin
            m_phase = 0; m_halted = 1'b0;
         end
         #1;
         ex = exp_out(m_phase, opcode, zero, m_halted);
         vectors++;
         if (obs !== ex) begin
            miscompares++;
            $display("FAIL random cyc%0d op=%0d z=%b mr=%b rst=%b: got %b want %b",
                     i, opcode, zero, mem_ready, rst, obs, ex);
         end
         tick();
         @(negedge clk);
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; opcode = 3'd2; zero = 1'b0; mem_ready = 1'b1;
      m_phase = 0; m_halted = 1'b0;
      test_reset();
      test_opcode_cycle(3'd2, 1'b0, "add");
      test_opcode_cycle(3'd1, 1'b1, "skz_taken");
      test_opcode_cycle(3'd1, 1'b0, "skz_not_taken");
      test_opcode_cycle(3'd6, 1'b0, "sto");
      test_opcode_cycle(3'd7, 1'b1, "jmp");
      test_opcode_cycle(3'd5, 1'b1, "lda");
      test_hlt();
      test_mem_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
